// File: rtl/src_ctrl_pkg.sv
// Shared types and constants for the sample-rate-converter control sequencer.
// SRC_CTRL_ERR_EN adds the error write-back state; other state codes do not move.
package src_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_INPUT  = 4'd1,
    S_ALLOC  = 4'd2,
    S_LOAD   = 4'd3,
    S_CONV   = 4'd4,
    S_ST_RES = 4'd5,
`ifdef SRC_CTRL_ERR_EN
    S_ST_ERR = 4'd6,
`endif
    S_NEXT   = 4'd7,
    S_OUTPUT = 4'd8
  } state_e;

  // Non-MAC cycles spent on each allocation entry, with and without error write-back.
  localparam int ENTRY_OVH_ERR   = 5;
  localparam int ENTRY_OVH_NOERR = 4;

  function automatic int idx_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/src_ctrl_decode.sv
// Moore decode from the sequencer state register to the datapath strobes and handshakes.
// SRC_CTRL_ERR_EN adds the rf_rw strobe in the error write-back state.
module src_ctrl_decode
  import src_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output logic       in_ready,
  output logic       out_valid,
  output logic       busy,
  output logic       pc_clr,
  output logic       pc_incr,
  output logic       fetch,
  output logic       readh_incrh,
  output logic       read_write,
  output logic       res_err,
  output logic       rf_rw,
  output logic       get_reg,
  output logic       new_in,
  output logic       new_out
);

  always_comb begin
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    busy        = 1'b1;
    pc_clr      = 1'b0;
    pc_incr     = 1'b0;
    fetch       = 1'b0;
    readh_incrh = 1'b0;
    read_write  = 1'b0;
    res_err     = 1'b0;
    rf_rw       = 1'b0;
    get_reg     = 1'b0;
    new_in      = 1'b0;
    new_out     = 1'b0;
    case (state_e'(state))
      S_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      S_INPUT: begin
        pc_clr  = 1'b1;
        rf_rw   = 1'b1;
        get_reg = 1'b1;
        new_in  = 1'b1;
      end
      S_ALLOC: fetch = 1'b1;
      S_LOAD: begin
        readh_incrh = 1'b1;
        get_reg     = 1'b1;
      end
      S_CONV: read_write = 1'b1;
      S_ST_RES: begin
        readh_incrh = 1'b1;
        res_err     = 1'b1;
        rf_rw       = 1'b1;
      end
`ifdef SRC_CTRL_ERR_EN
      S_ST_ERR: rf_rw = 1'b1;
`endif
      S_NEXT: pc_incr = 1'b1;
      S_OUTPUT: begin
        out_valid = 1'b1;
        new_out   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/src_ctrl_seq.sv
// Frame/channel/entry/tap sequencer for the SRC datapath; strobes decoded from the state register.
// SRC_CTRL_ERR_EN inserts ST_ERR between ST_RES and NEXT.
//
// state  | meaning
// IDLE   | waiting for an input frame (in_ready high)
// INPUT  | frame accepted, PC and indices cleared
// ALLOC  | fetch the current allocation entry
// LOAD   | load operands for the entry
// CONV   | TAPS-cycle MAC convolution
// ST_RES | result write-back
// ST_ERR | error write-back (SRC_CTRL_ERR_EN only)
// NEXT   | advance the allocation list
// OUTPUT | present channel sample, wait for out_ready
module src_ctrl_seq
  import src_ctrl_pkg::*;
#(
  parameter int TAPS        = 16,
  parameter int CHANNELS    = 2,
  parameter int ALLOC_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          pc_clr,
  output logic                          pc_incr,
  output logic                          fetch,
  output logic                          readh_incrh,
  output logic                          read_write,
  output logic                          res_err,
  output logic                          rf_rw,
  output logic                          get_reg,
  output logic                          new_in,
  output logic                          new_out,
  output logic [idx_w(TAPS)-1:0]        tap_idx,
  output logic [idx_w(ALLOC_DEPTH)-1:0] entry_idx,
  output logic [idx_w(CHANNELS)-1:0]    ch_idx,
  output logic                          busy
);

  localparam int TW = idx_w(TAPS);
  localparam int EW = idx_w(ALLOC_DEPTH);
  localparam int CW = idx_w(CHANNELS);

  localparam logic [TW-1:0] TAP_LAST   = TW'(TAPS - 1);
  localparam logic [EW-1:0] ENTRY_LAST = EW'(ALLOC_DEPTH - 1);
  localparam logic [CW-1:0] CH_LAST    = CW'(CHANNELS - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tap_q, tap_d;
  logic [EW-1:0]   entry_q, entry_d;
  logic [CW-1:0]   ch_q, ch_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      tap_q   <= '0;
      entry_q <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      tap_q   <= tap_d;
      entry_q <= entry_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tap_d   = tap_q;
    entry_d = entry_q;
    ch_d    = ch_q;
    case (state_q)
      S_IDLE: if (in_valid) state_d = S_INPUT;
      S_INPUT: begin
        tap_d   = '0;
        entry_d = '0;
        ch_d    = '0;
        state_d = S_ALLOC;
      end
      S_ALLOC: state_d = S_LOAD;
      S_LOAD:  state_d = S_CONV;
      S_CONV: begin
        if (tap_q == TAP_LAST) begin
          tap_d   = '0;
          state_d = S_ST_RES;
        end else begin
          tap_d = tap_q + 1'b1;
        end
      end
`ifdef SRC_CTRL_ERR_EN
      S_ST_RES: state_d = S_ST_ERR;
      S_ST_ERR: state_d = S_NEXT;
`else
      S_ST_RES: state_d = S_NEXT;
`endif
      S_NEXT: begin
        if (entry_q == ENTRY_LAST) begin
          entry_d = '0;
          state_d = S_OUTPUT;
        end else begin
          entry_d = entry_q + 1'b1;
          state_d = S_ALLOC;
        end
      end
      // Leave the channel index at 0 after the last channel so IDLE looks like reset.
      S_OUTPUT: begin
        if (out_ready) begin
          if (ch_q == CH_LAST) begin
            ch_d    = '0;
            state_d = S_IDLE;
          end else begin
            ch_d    = ch_q + 1'b1;
            state_d = S_ALLOC;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign tap_idx   = tap_q;
  assign entry_idx = entry_q;
  assign ch_idx    = ch_q;

  src_ctrl_decode u_decode (
    .state       (state_q),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .busy        (busy),
    .pc_clr      (pc_clr),
    .pc_incr     (pc_incr),
    .fetch       (fetch),
    .readh_incrh (readh_incrh),
    .read_write  (read_write),
    .res_err     (res_err),
    .rf_rw       (rf_rw),
    .get_reg     (get_reg),
    .new_in      (new_in),
    .new_out     (new_out)
  );

endmodule

// File: tb/tb_src_ctrl_seq.sv
// Self-checking bench for src_ctrl_seq: directed scenarios plus a randomized run against a frame-plan model.
// Expectations follow SRC_CTRL_ERR_EN when it is defined for the build.
module tb_src_ctrl_seq;

  localparam int TAPS = 16;
  localparam int CHN  = 2;
  localparam int AD   = 8;
`ifdef SRC_CTRL_ERR_EN
  localparam int OVH     = 5;
  localparam bit HAS_ERR = 1'b1;
`else
  localparam int OVH     = 4;
  localparam bit HAS_ERR = 1'b0;
`endif
  localparam int FRAME_LEN = 1 + CHN * (AD * (TAPS + OVH) + 1);

  typedef enum int {PH_IDLE, PH_INPUT, PH_ALLOC, PH_LOAD, PH_CONV, PH_RES, PH_ERR, PH_NEXT, PH_OUTPUT} ph_e;
  typedef struct {
    ph_e ph;
    int  ch;
    int  ent;
    int  tap;
  } step_t;

  step_t plan[$];
  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, busy;
  logic pc_clr, pc_incr, fetch, readh_incrh, read_write, res_err, rf_rw, get_reg, new_in, new_out;
  logic [3:0] tap_idx;
  logic [2:0] entry_idx;
  logic [0:0] ch_idx;

  logic in_valid_m = 1'b0, out_ready_m = 1'b1;
  logic in_ready_m, out_valid_m, busy_m;
  logic pc_clr_m, pc_incr_m, fetch_m, readh_incrh_m, read_write_m, res_err_m, rf_rw_m, get_reg_m, new_in_m, new_out_m;
  logic [0:0] tap_idx_m, entry_idx_m, ch_idx_m;

  logic [9:0] str, str_m;
  assign str   = {pc_clr, pc_incr, fetch, readh_incrh, read_write, res_err, rf_rw, get_reg, new_in, new_out};
  assign str_m = {pc_clr_m, pc_incr_m, fetch_m, readh_incrh_m, read_write_m, res_err_m, rf_rw_m, get_reg_m,
                  new_in_m, new_out_m};

  always #5 clk = ~clk;

  src_ctrl_seq #(.TAPS(TAPS), .CHANNELS(CHN), .ALLOC_DEPTH(AD)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .pc_clr(pc_clr), .pc_incr(pc_incr), .fetch(fetch),
    .readh_incrh(readh_incrh), .read_write(read_write), .res_err(res_err), .rf_rw(rf_rw),
    .get_reg(get_reg), .new_in(new_in), .new_out(new_out), .tap_idx(tap_idx),
    .entry_idx(entry_idx), .ch_idx(ch_idx), .busy(busy)
  );

  src_ctrl_seq #(.TAPS(1), .CHANNELS(1), .ALLOC_DEPTH(1)) dut_min (
    .clk(clk), .rst(rst), .in_valid(in_valid_m), .in_ready(in_ready_m), .out_valid(out_valid_m),
    .out_ready(out_ready_m), .pc_clr(pc_clr_m), .pc_incr(pc_incr_m), .fetch(fetch_m),
    .readh_incrh(readh_incrh_m), .read_write(read_write_m), .res_err(res_err_m), .rf_rw(rf_rw_m),
    .get_reg(get_reg_m), .new_in(new_in_m), .new_out(new_out_m), .tap_idx(tap_idx_m),
    .entry_idx(entry_idx_m), .ch_idx(ch_idx_m), .busy(busy_m)
  );

  // Strobe order: pc_clr pc_incr fetch readh_incrh read_write res_err rf_rw get_reg new_in new_out
  function automatic logic [9:0] exp_str(ph_e ph);
    logic [9:0] s;
    s = '0;
    case (ph)
      PH_INPUT:  begin s[9] = 1'b1; s[3] = 1'b1; s[2] = 1'b1; s[1] = 1'b1; end
      PH_ALLOC:  s[7] = 1'b1;
      PH_LOAD:   begin s[6] = 1'b1; s[2] = 1'b1; end
      PH_CONV:   s[5] = 1'b1;
      PH_RES:    begin s[6] = 1'b1; s[4] = 1'b1; s[3] = 1'b1; end
      PH_ERR:    s[3] = 1'b1;
      PH_NEXT:   s[8] = 1'b1;
      PH_OUTPUT: s[0] = 1'b1;
      default:   s = '0;
    endcase
    return s;
  endfunction

  // Expected cycle-by-cycle plan of one frame with out_ready held high.
  function automatic void build_plan(int taps, int chn, int ad);
    plan.delete();
    plan.push_back('{PH_INPUT, 0, 0, 0});
    for (int c = 0; c < chn; c++) begin
      for (int e = 0; e < ad; e++) begin
        plan.push_back('{PH_ALLOC, c, e, 0});
        plan.push_back('{PH_LOAD, c, e, 0});
        for (int t = 0; t < taps; t++) plan.push_back('{PH_CONV, c, e, t});
        plan.push_back('{PH_RES, c, e, 0});
        if (HAS_ERR) plan.push_back('{PH_ERR, c, e, 0});
        plan.push_back('{PH_NEXT, c, e, 0});
      end
      plan.push_back('{PH_OUTPUT, c, 0, 0});
    end
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++; $display("FAIL reset_hs got in_ready/busy/out_valid=%b want 100", {in_ready, busy, out_valid});
    end
    checks++;
    if (str !== 10'd0) begin errors++; $display("FAIL reset_strobes got %b want 0", str); end
    checks++;
    if ({tap_idx, entry_idx, ch_idx} !== 8'd0) begin
      errors++; $display("FAIL reset_idx got %0d/%0d/%0d want 0/0/0", tap_idx, entry_idx, ch_idx);
    end
    checks++;
    if (in_ready_m !== 1'b1 || str_m !== 10'd0) begin
      errors++; $display("FAIL reset_min got in_ready=%b strobes=%b want 1/0", in_ready_m, str_m);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_frame();
    int cyc, n_pci, n_rw, n_out, n_in;
    cyc = 0; n_pci = 0; n_rw = 0; n_out = 0; n_in = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (new_in !== 1'b1) begin errors++; $display("FAIL frame_latency new_in got %b want 1", new_in); end
    while (busy === 1'b1 && cyc < 5000) begin
      n_pci += int'(pc_incr); n_rw += int'(read_write); n_out += int'(new_out); n_in += int'(new_in);
      cyc++;
      @(negedge clk);
    end
    checks++;
    if (cyc != FRAME_LEN) begin errors++; $display("FAIL frame_len got %0d want %0d", cyc, FRAME_LEN); end
    checks++;
    if (n_pci != CHN * AD) begin errors++; $display("FAIL frame_pc_incr got %0d want %0d", n_pci, CHN * AD); end
    checks++;
    if (n_rw != CHN * AD * TAPS) begin
      errors++; $display("FAIL frame_read_write got %0d want %0d", n_rw, CHN * AD * TAPS);
    end
    checks++;
    if (n_out != CHN) begin errors++; $display("FAIL frame_new_out got %0d want %0d", n_out, CHN); end
    checks++;
    if (n_in != 1) begin errors++; $display("FAIL frame_new_in got %0d want 1", n_in); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL frame_idle in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_stall();
    int cyc, stalls;
    cyc = 0; stalls = 0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    while (busy === 1'b1 && cyc < 5000) begin
      if (out_valid === 1'b1 && ch_idx === 1'b0 && stalls < 10) begin
        out_ready = 1'b0;
        if (stalls > 0) begin
          checks++;
          if (out_valid !== 1'b1 || ch_idx !== 1'b0) begin
            errors++; $display("FAIL stall_hold got out_valid=%b ch=%0d want 1/0", out_valid, ch_idx);
          end
        end
        stalls++;
      end else begin
        out_ready = 1'b1;
      end
      cyc++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    checks++;
    if (cyc != FRAME_LEN + 10) begin
      errors++; $display("FAIL stall_len got %0d want %0d", cyc, FRAME_LEN + 10);
    end
  endtask

  task automatic test_mid_reset();
    int cyc;
    out_ready = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 1;
    while (cyc < 50) begin @(negedge clk); cyc++; end
    checks++;
    if (read_write !== 1'b1) begin errors++; $display("FAIL midrst_conv read_write got %b want 1", read_write); end
    rst = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100 || str !== 10'd0) begin
      errors++; $display("FAIL midrst_idle got hs=%b strobes=%b want 100/0", {in_ready, busy, out_valid}, str);
    end
    checks++;
    if ({tap_idx, entry_idx, ch_idx} !== 8'd0) begin
      errors++; $display("FAIL midrst_idx got %0d/%0d/%0d want 0/0/0", tap_idx, entry_idx, ch_idx);
    end
    rst = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (busy === 1'b1 && cyc < 5000) begin cyc++; @(negedge clk); end
    checks++;
    if (cyc != FRAME_LEN) begin errors++; $display("FAIL midrst_frame got %0d want %0d", cyc, FRAME_LEN); end
  endtask

  task automatic test_back_to_back();
    int seen[$];
    int wait_c;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 1; i <= 2 * (FRAME_LEN + 1) + 5; i++) begin
      @(negedge clk);
      if (new_in === 1'b1) seen.push_back(i);
    end
    in_valid = 1'b0;
    checks++;
    if (seen.size() != 3) begin
      errors++; $display("FAIL b2b_count got %0d want 3", seen.size());
    end else begin
      checks++;
      if (seen[0] != 1) begin errors++; $display("FAIL b2b_first got %0d want 1", seen[0]); end
      for (int k = 1; k < 3; k++) begin
        checks++;
        if (seen[k] - seen[k-1] != FRAME_LEN + 1) begin
          errors++; $display("FAIL b2b_gap got %0d want %0d", seen[k] - seen[k-1], FRAME_LEN + 1);
        end
      end
    end
    wait_c = 0;
    while (busy === 1'b1 && wait_c < 2 * FRAME_LEN) begin wait_c++; @(negedge clk); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_drain busy got %b want 0", busy); end
  endtask

  task automatic test_min();
    build_plan(1, 1, 1);
    in_valid_m = 1'b1;
    for (int k = 0; k < plan.size(); k++) begin
      @(negedge clk);
      in_valid_m = 1'b0;
      checks++;
      if (str_m !== exp_str(plan[k].ph) || busy_m !== 1'b1 || {tap_idx_m, entry_idx_m, ch_idx_m} !== 3'd0) begin
        errors++;
        $display("FAIL min_step%0d got strobes=%b busy=%b idx=%b want %b/1/000", k, str_m, busy_m,
                 {tap_idx_m, entry_idx_m, ch_idx_m}, exp_str(plan[k].ph));
      end
    end
    @(negedge clk);
    checks++;
    if (in_ready_m !== 1'b1 || busy_m !== 1'b0) begin
      errors++; $display("FAIL min_end got in_ready=%b busy=%b want 1/0", in_ready_m, busy_m);
    end
  endtask

  task automatic test_random(int ncyc);
    int pos;
    step_t e;
    build_plan(TAPS, CHN, AD);
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    pos = -1;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (pos < 0) e = '{PH_IDLE, 0, 0, 0};
      else e = plan[pos];
      checks++;
      if (str !== exp_str(e.ph)) begin
        errors++; $display("FAIL rnd_strobes cyc %0d got %b want %b", i, str, exp_str(e.ph));
      end
      checks++;
      if ({in_ready, busy, out_valid} !== {e.ph == PH_IDLE, e.ph != PH_IDLE, e.ph == PH_OUTPUT}) begin
        errors++; $display("FAIL rnd_hs cyc %0d got %b phase %0d", i, {in_ready, busy, out_valid}, e.ph);
      end
      if (e.ph != PH_IDLE && e.ph != PH_INPUT) begin
        checks++;
        if (int'(tap_idx) != e.tap || int'(entry_idx) != e.ent || int'(ch_idx) != e.ch) begin
          errors++;
          $display("FAIL rnd_idx cyc %0d got %0d/%0d/%0d want %0d/%0d/%0d", i, tap_idx, entry_idx, ch_idx,
                   e.tap, e.ent, e.ch);
        end
      end
      checks++;
      if ($countones({pc_clr, pc_incr, fetch, read_write}) > 1) begin
        errors++; $display("FAIL rnd_mutex cyc %0d got %b want at most one", i, {pc_clr, pc_incr, fetch, read_write});
      end
      rst       = ($urandom_range(0, 599) == 0);
      in_valid  = ($urandom_range(0, 3) == 0);
      out_ready = $urandom_range(0, 1) == 1;
      if (rst) pos = -1;
      else if (pos < 0) begin
        if (in_valid) pos = 0;
      end else if (!(e.ph == PH_OUTPUT && !out_ready)) begin
        pos++;
        if (pos == plan.size()) pos = -1;
      end
    end
    rst = 1'b0; in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    test_min();
    test_random(4000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout reached, checks %0d", checks);
    $fatal(1, "timeout");
  end

endmodule
